// File: rtl/rca_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_ctrl_pkg
// Description : Shared constants, FSM state encoding and the counter-width helper
//               used by the nibble-serial adder sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package rca_seq_ctrl_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // A single-nibble build still needs a 1-bit counter.
    function automatic int cnt_width(input int nib);
        return (nib > 1) ? $clog2(nib) : 1;
    endfunction

endpackage : rca_seq_ctrl_pkg
`default_nettype wire

// File: rtl/rca_seq_ctrl_rca.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_ctrl_rca
// Description : 4-bit ripple-carry adder; the only arithmetic in the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seq_ctrl_rca
    import rca_seq_ctrl_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                c_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                c_o
);

    logic [NIBBLE_W:0] carry_w;

    assign carry_w[0] = c_i;

    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_bit
        assign s_o[i]         = a_i[i] ^ b_i[i] ^ carry_w[i];
        assign carry_w[i + 1] = (a_i[i] & b_i[i]) | (carry_w[i] & (a_i[i] ^ b_i[i]));
    end

    assign c_o = carry_w[NIBBLE_W];

endmodule : rca_seq_ctrl_rca
`default_nettype wire

// File: rtl/rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rca_seq_ctrl
// Description : Sequences one 4-bit ripple-carry adder across a WIDTH-bit operand
//               pair, one nibble per cycle, with valid/ready on both sides.
//               Define RCA_SEQ_SUB_EN to add the 'sub' port (a - b mode).
// Revision    : 1.0 - initial release
// ============================================================================
module rca_seq_ctrl
    import rca_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef RCA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NIB   = WIDTH / NIBBLE_W;
    localparam int CNT_W = cnt_width(NIB);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIB - 1);

    if ((WIDTH < NIBBLE_W) || ((WIDTH % NIBBLE_W) != 0)) begin : g_bad_width
        $error("rca_seq_ctrl: WIDTH must be a multiple of 4 and at least 4");
    end

    state_e                          state_q, state_d;
    logic [CNT_W-1:0]                nib_q, nib_d;
    logic [NIB-1:0][NIBBLE_W-1:0]    a_q, a_d;
    logic [NIB-1:0][NIBBLE_W-1:0]    b_q, b_d;
    logic [NIB-1:0][NIBBLE_W-1:0]    sum_q, sum_d;
    logic                            carry_q, carry_d;
    logic                            cout_q, cout_d;
    logic                            ovf_q, ovf_d;
    logic                            sub_eff;

    logic [NIBBLE_W-1:0]             rca_a, rca_b, rca_s;
    logic                            rca_c;

`ifdef RCA_SEQ_SUB_EN
    logic sub_q, sub_d;
    assign sub_eff = sub_q;
`else
    assign sub_eff = 1'b0;
`endif

    // Subtraction is a + ~b + 1: invert B per nibble and seed the carry with 1.
    assign rca_a = a_q[nib_q];
    assign rca_b = b_q[nib_q] ^ {NIBBLE_W{sub_eff}};

    rca_seq_ctrl_rca u_rca (
        .a_i (rca_a),
        .b_i (rca_b),
        .c_i (carry_q),
        .s_o (rca_s),
        .c_o (rca_c)
    );

    always_comb begin
        state_d = state_q;
        nib_d   = nib_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
`ifdef RCA_SEQ_SUB_EN
        sub_d   = sub_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    nib_d   = '0;
`ifdef RCA_SEQ_SUB_EN
                    sub_d   = sub;
                    carry_d = sub ? 1'b1 : cin;
`else
                    carry_d = cin;
`endif
                end
            end
            ST_RUN: begin
                sum_d[nib_q] = rca_s;
                carry_d      = rca_c;
                if (nib_q == LAST_IDX) begin
                    state_d = ST_DONE;
                    cout_d  = rca_c;
                    // Sign of the effective B operand is b_msb ^ sub.
                    ovf_d   = (a_q[NIB-1][NIBBLE_W-1] == (b_q[NIB-1][NIBBLE_W-1] ^ sub_eff))
                           && (rca_s[NIBBLE_W-1] != a_q[NIB-1][NIBBLE_W-1]);
                end else begin
                    nib_d = nib_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            nib_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
`ifdef RCA_SEQ_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            nib_q   <= nib_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
`ifdef RCA_SEQ_SUB_EN
            sub_q   <= sub_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule : rca_seq_ctrl
`default_nettype wire

// File: tb/tb_rca_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rca_seq_ctrl
// Description : Table-driven check of rca_seq_ctrl at WIDTH=16 and WIDTH=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rca_seq_ctrl;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        cin;
        logic [15:0] exp_sum;
        logic        exp_cout;
        logic        exp_ovf;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] a, b, sum;
    logic        cin, cout, ovf, sub;

    logic        in_valid4, in_ready4, out_valid4, out_ready4;
    logic [3:0]  a4, b4, sum4;
    logic        cin4, cout4, ovf4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rca_seq_ctrl #(.WIDTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef RCA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    rca_seq_ctrl #(.WIDTH(4)) dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .a         (a4),
        .b         (b4),
        .cin       (cin4),
`ifdef RCA_SEQ_SUB_EN
        .sub       (1'b0),
`endif
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .sum       (sum4),
        .cout      (cout4),
        .ovf       (ovf4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Issue one operation; returns result and accept-to-out_valid latency (-1 on timeout).
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tb_b, input logic tcin,
                         input bit release_out, output logic [15:0] rs, output logic rc,
                         output logic ro, output int lat);
        @(negedge clk);
        chk("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = ta;
        b = tb_b;
        cin = tcin;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = 16'hDEAD;
        b = 16'hBEEF;
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
        rs = sum;
        rc = cout;
        ro = ovf;
        if (release_out) begin
            @(negedge clk);
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            chk("idle_after_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        end
    endtask

    vec_t        vecs[8];
    logic [15:0] rs;
    logic        rc, ro;
    int          lat;

    initial begin
        vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vecs[1] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[2] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vecs[4] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0, 1'b0};

        reset = 1'b1;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {27'd0, in_ready, out_valid, sum == 16'd0, cout, ovf},
                           {27'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b1, rs, rc, ro, lat);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
            chk($sformatf("vec%0d_sum", i), 32'(rs), 32'(vecs[i].exp_sum));
            chk($sformatf("vec%0d_cout_ovf", i), {30'd0, rc, ro},
                {30'd0, vecs[i].exp_cout, vecs[i].exp_ovf});
        end

        // Backpressure: result held stable for 5 cycles, no accept while DONE.
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0, rs, rc, ro, lat);
        chk("bp_latency", 32'(lat), 32'd4);
        in_valid = 1'b1;
        a = 16'h1111;
        b = 16'h2222;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d", k), {12'd0, sum, 1'b0, cout, ovf, out_valid, in_ready},
                {12'd0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0});
        end
        in_valid = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
        do_op(16'h1234, 16'h4321, 1'b1, 1'b1, rs, rc, ro, lat);
        chk("bp_next_op_sum", 32'(rs), 32'h5556);
        chk("bp_next_op_latency", 32'(lat), 32'd4);

        // Reset during the 2nd RUN cycle discards the partial result.
        @(negedge clk);
        in_valid = 1'b1; a = 16'hFFFF; b = 16'h0001; cin = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrun_reset", {11'd0, in_ready, out_valid, sum, cout, ovf},
                            {11'd0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        do_op(16'h7FFF, 16'h0001, 1'b0, 1'b1, rs, rc, ro, lat);
        chk("post_reset_sum", 32'(rs), 32'h8000);
        chk("post_reset_flags_lat", {28'd0, rc, ro, 2'(lat)}, {28'd0, 1'b0, 1'b1, 2'd0});

        // WIDTH=4 instance: single-cycle latency.
        @(negedge clk);
        in_valid4 = 1'b1; a4 = 4'h9; b4 = 4'h8; cin4 = 1'b0;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        chk("w4_running", {30'd0, out_valid4, in_ready4}, {30'd0, 1'b0, 1'b0});
        @(posedge clk);
        #1;
        chk("w4_result", {24'd0, out_valid4, sum4, cout4, ovf4}, {24'd0, 1'b1, 4'h1, 1'b1, 1'b1});
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;
        @(negedge clk);
        in_valid4 = 1'b1; a4 = 4'h7; b4 = 4'h1; cin4 = 1'b0;
        @(posedge clk);
        #1;
        in_valid4 = 1'b0;
        @(posedge clk);
        #1;
        chk("w4_result2", {24'd0, out_valid4, sum4, cout4, ovf4}, {24'd0, 1'b1, 4'h8, 1'b0, 1'b1});
        @(negedge clk);
        out_ready4 = 1'b1;
        @(posedge clk);
        #1;
        out_ready4 = 1'b0;

`ifdef RCA_SEQ_SUB_EN
        sub = 1'b1;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, rs, rc, ro, lat);
        chk("sub_5_minus_7", {13'd0, rs, rc, ro, 1'b0}, {13'd0, 16'hFFFE, 1'b0, 1'b0, 1'b0});
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, rs, rc, ro, lat);
        chk("sub_min_minus_1", {13'd0, rs, rc, ro, 1'b0}, {13'd0, 16'h7FFF, 1'b1, 1'b1, 1'b0});
        sub = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rca_seq_ctrl
`default_nettype wire
